// File: rtl/vga_scanout_if.sv
// Pixel-plot bus from the draw logic into the VGA scanout framebuffer.
// One write per CLOCK_50 edge while plot is high.
interface vga_scanout_if;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (output x, y, colour, plot);
    modport slave  (input  x, y, colour, plot);
endinterface

// File: rtl/vga_scanout.sv
// VGA display end: a 320x240x3 framebuffer written from CLOCK_50 and scanned
// out as 640x480@60 with every stored pixel doubled 2x2.
module vga_scanout #(
    parameter int         H_ACTIVE  = 640,
    parameter int         H_FP      = 16,
    parameter int         H_SYNC    = 96,
    parameter int         H_BP      = 48,
    parameter int         V_ACTIVE  = 480,
    parameter int         V_FP      = 10,
    parameter int         V_SYNC    = 2,
    parameter int         V_BP      = 33,
    parameter int         FB_W      = 320,
    parameter int         FB_H      = 240,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic         CLOCK_50,
    input  logic         resetn,
    vga_scanout_if.slave draw,
    output logic         VGA_CLK,
    output logic         VGA_HS,
    output logic         VGA_VS,
    output logic         VGA_BLANK_N,
    output logic         VGA_SYNC_N,
    output logic [9:0]   VGA_R,
    output logic [9:0]   VGA_G,
    output logic [9:0]   VGA_B,
    output logic         frame_start
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [1:0]  rst_sync;
    logic        rst_n;
    logic        pix_en;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic        h_last;
    logic        v_last;
    logic        active_s0;
    logic        hs_s0;
    logic        vs_s0;
    logic [16:0] rd_addr;
    logic [16:0] wr_addr;
    logic        wr_en;
    logic [2:0]  mem [FB_DEPTH];
    logic [2:0]  rd_raw;
    logic [2:0]  pix;
    logic        active_s1;
    logic        hs_s1;
    logic        vs_s1;

    // Reset asserts immediately but only releases on a clock edge.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            pix_en  <= 1'b0;
            VGA_CLK <= 1'b0;
        end else begin
            pix_en  <= ~pix_en;
            VGA_CLK <= pix_en;
        end
    end

    assign h_last = (hcount == 10'(H_TOTAL - 1));
    assign v_last = (vcount == 10'(V_TOTAL - 1));

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && h_last && v_last;
            if (pix_en) begin
                if (h_last) begin
                    hcount <= '0;
                    vcount <= v_last ? '0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end
        end
    end

    // Range check on x and y separately so an overflowing x never wraps into the next row.
    always_comb begin
        active_s0 = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
        hs_s0     = !((hcount >= 10'(HS_START)) && (hcount < 10'(HS_END)));
        vs_s0     = !((vcount >= 10'(VS_START)) && (vcount < 10'(VS_END)));
        rd_addr   = 17'(vcount[9:1]) * 17'(FB_W) + 17'(hcount[9:1]);
        wr_addr   = 17'(draw.y) * 17'(FB_W) + 17'(draw.x);
        wr_en     = draw.plot && (draw.x < 10'(FB_W)) && (draw.y < 10'(FB_H));
    end

    // RAM stores colour ^ BG_COLOUR so a zero power-up array reads back as the background.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) mem[wr_addr] <= draw.colour ^ BG_COLOUR;
    end

    always_ff @(posedge CLOCK_50) begin
        if (pix_en && active_s0) rd_raw <= mem[rd_addr];
    end

    assign pix = rd_raw ^ BG_COLOUR;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            active_s1   <= 1'b0;
            hs_s1       <= 1'b1;
            vs_s1       <= 1'b1;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (pix_en) begin
            active_s1   <= active_s0;
            hs_s1       <= hs_s0;
            vs_s1       <= vs_s0;
            VGA_HS      <= hs_s1;
            VGA_VS      <= vs_s1;
            VGA_BLANK_N <= active_s1;
            VGA_R       <= active_s1 ? {10{pix[2]}} : 10'd0;
            VGA_G       <= active_s1 ? {10{pix[1]}} : 10'd0;
            VGA_B       <= active_s1 ? {10{pix[0]}} : 10'd0;
        end
    end

    assign VGA_SYNC_N = 1'b1;
endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken raster with the real 320x240 framebuffer.
// Expected pixels and per-frame totals are queued as writes are issued and checked as the scan passes.
module tb_vga_scanout;
    localparam int HA  = 64;
    localparam int HFP = 4;
    localparam int HSW = 8;
    localparam int HBP = 4;
    localparam int VA  = 16;
    localparam int VFP = 2;
    localparam int VSW = 2;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int FT  = HT * VT;

    typedef struct {
        int         p;
        int         f;
        int         h;
        int         v;
        logic [2:0] rgb;
    } pix_t;

    typedef struct {
        int f;
        int lit;
    } lit_t;

    logic       clk;
    logic       resetn;
    logic       vga_clk;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic       sync_n;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
    logic       frame_start;

    int   tests_run;
    int   tests_failed;
    int   tick_cnt;
    pix_t sb_q[$];
    lit_t lit_q[$];

    vga_scanout_if draw ();

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .FB_W(320), .FB_H(240), .BG_COLOUR(3'b000)
    ) dut (
        .CLOCK_50(clk),
        .resetn(resetn),
        .draw(draw.slave),
        .VGA_CLK(vga_clk),
        .VGA_HS(hs),
        .VGA_VS(vs),
        .VGA_BLANK_N(blank_n),
        .VGA_SYNC_N(sync_n),
        .VGA_R(r),
        .VGA_G(g),
        .VGA_B(b),
        .frame_start(frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #(20 * 100000);
        $display("[TB] FAIL watchdog: simulation still running after 100000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    always @(posedge vga_clk or negedge resetn) begin
        if (!resetn) tick_cnt <= 0;
        else         tick_cnt <= tick_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_vga_clk"}, 32'(vga_clk), 32'd0);
        checkOutput({tag, "_hs"}, 32'(hs), 32'd1);
        checkOutput({tag, "_vs"}, 32'(vs), 32'd1);
        checkOutput({tag, "_blank_n"}, 32'(blank_n), 32'd0);
        checkOutput({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
        checkOutput({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        checkOutput({tag, "_sync_n"}, 32'(sync_n), 32'd1);
    endtask

    // Called on a falling edge; the write lands on the following rising edge.
    task automatic applyStimulus(input int px, input int py, input logic [2:0] c);
        draw.x      = 10'(px);
        draw.y      = 10'(py);
        draw.colour = c;
        draw.plot   = 1'b1;
        @(negedge clk);
        draw.plot   = 1'b0;
    endtask

    task automatic waitTick(input int target);
        int budget;
        budget = 2 * (target - tick_cnt) + 20;
        while (tick_cnt < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (tick_cnt < target) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL tick_wait: reached %0d, required %0d", tick_cnt, target);
        end
    endtask

    task automatic pushPix(input int f, input int h, input int v, input logic [2:0] rgb);
        pix_t e;
        e.p   = f * FT + v * HT + h;
        e.f   = f;
        e.h   = h;
        e.v   = v;
        e.rgb = rgb;
        sb_q.push_back(e);
    endtask

    task automatic pushLit(input int f, input int lit);
        lit_t e;
        e.f   = f;
        e.lit = lit;
        lit_q.push_back(e);
    endtask

    // Monitor: outputs after tick t show the raster position the counters held after tick t-2.
    int   last_tick;
    int   cur_p;
    int   acc_hs;
    int   acc_vs;
    int   acc_blank;
    int   acc_lit;
    int   acc_dirty;
    int   acc_fs;
    logic prev_hs;
    logic prev_vs;
    bit   hs_seen;
    bit   vs_seen;

    always @(negedge clk) begin
        if (resetn !== 1'b1) begin
            last_tick = 0;
            acc_hs    = 0;
            acc_vs    = 0;
            acc_blank = 0;
            acc_lit   = 0;
            acc_dirty = 0;
            acc_fs    = 0;
            prev_hs   = 1'b1;
            prev_vs   = 1'b1;
            hs_seen   = 1'b0;
            vs_seen   = 1'b0;
        end else begin
            if (frame_start === 1'b1) acc_fs++;
            if (tick_cnt != last_tick) begin
                last_tick = tick_cnt;
                if (!hs_seen && prev_hs === 1'b1 && hs === 1'b0) begin
                    hs_seen = 1'b1;
                    checkOutput("first_hs_fall_tick", 32'(tick_cnt), 32'(HA + HFP + 2));
                end
                if (!vs_seen && prev_vs === 1'b1 && vs === 1'b0) begin
                    vs_seen = 1'b1;
                    checkOutput("first_vs_fall_tick", 32'(tick_cnt), 32'((VA + VFP) * HT + 2));
                end
                prev_hs = hs;
                prev_vs = vs;
                if (tick_cnt >= 2) begin
                    cur_p = tick_cnt - 2;
                    if (hs !== 1'b1) acc_hs++;
                    if (vs !== 1'b1) acc_vs++;
                    if (blank_n === 1'b1) acc_blank++;
                    if (blank_n === 1'b1 && {r, g, b} != 30'd0) acc_lit++;
                    if (blank_n !== 1'b1 && {r, g, b} != 30'd0) acc_dirty++;
                    while (sb_q.size() > 0 && sb_q[0].p < cur_p) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL pix_missed f%0d h%0d v%0d: scan at %0d, required %0d",
                                 sb_q[0].f, sb_q[0].h, sb_q[0].v, cur_p, sb_q[0].p);
                        void'(sb_q.pop_front());
                    end
                    if (sb_q.size() > 0 && sb_q[0].p == cur_p) begin
                        pix_t e;
                        e = sb_q.pop_front();
                        checkOutput($sformatf("pix_blank_n f%0d h%0d v%0d", e.f, e.h, e.v),
                                    32'(blank_n), 32'd1);
                        checkOutput($sformatf("pix_rgb f%0d h%0d v%0d", e.f, e.h, e.v),
                                    32'({r, g, b}),
                                    32'({{10{e.rgb[2]}}, {10{e.rgb[1]}}, {10{e.rgb[0]}}}));
                    end
                    if (cur_p % FT == FT - 1) begin
                        checkOutput($sformatf("hs_low_ticks f%0d", cur_p / FT), 32'(acc_hs), 32'(HSW * VT));
                        checkOutput($sformatf("vs_low_ticks f%0d", cur_p / FT), 32'(acc_vs), 32'(VSW * HT));
                        checkOutput($sformatf("blank_n_high_ticks f%0d", cur_p / FT), 32'(acc_blank), 32'(HA * VA));
                        checkOutput($sformatf("frame_start_pulses f%0d", cur_p / FT), 32'(acc_fs), 32'd1);
                        checkOutput($sformatf("rgb_while_blanked f%0d", cur_p / FT), 32'(acc_dirty), 32'd0);
                        if (lit_q.size() > 0 && lit_q[0].f == cur_p / FT) begin
                            lit_t le;
                            le = lit_q.pop_front();
                            checkOutput($sformatf("lit_pixels f%0d", le.f), 32'(acc_lit), 32'(le.lit));
                        end
                        acc_hs    = 0;
                        acc_vs    = 0;
                        acc_blank = 0;
                        acc_lit   = 0;
                        acc_dirty = 0;
                        acc_fs    = 0;
                    end
                end
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetn       = 1'b0;
        draw.x       = '0;
        draw.y       = '0;
        draw.colour  = '0;
        draw.plot    = 1'b0;
        repeat (10) @(negedge clk);
        checkResetOutputs("reset_hold");
        resetn = 1'b1;
        @(negedge clk);
        checkResetOutputs("reset_release");

        // Frame 0: untouched framebuffer.
        pushPix(0, 10, 6, 3'b000);
        pushPix(0, 11, 7, 3'b000);
        pushLit(0, 0);

        // During frame 0 blanking: one real write, then two out-of-range ones.
        waitTick(VA * HT + 10);
        applyStimulus(5, 3, 3'b101);
        applyStimulus(320, 0, 3'b111);
        applyStimulus(0, 240, 3'b111);
        pushPix(1, 0, 2, 3'b000);
        pushPix(1, 1, 3, 3'b000);
        pushPix(1, 9, 6, 3'b000);
        pushPix(1, 10, 6, 3'b101);
        pushPix(1, 11, 6, 3'b101);
        pushPix(1, 12, 6, 3'b000);
        pushPix(1, 10, 7, 3'b101);
        pushPix(1, 11, 7, 3'b101);
        pushPix(1, 10, 8, 3'b000);
        pushLit(1, 4);

        // Write (20,5) on the tick that makes the last frame-2 read of it (scan h=41, v=11).
        pushPix(2, 40, 10, 3'b000);
        pushPix(2, 41, 10, 3'b000);
        pushPix(2, 40, 11, 3'b000);
        pushPix(2, 41, 11, 3'b000);
        pushLit(2, 4);
        pushPix(3, 10, 6, 3'b101);
        pushPix(3, 40, 10, 3'b010);
        pushPix(3, 41, 10, 3'b010);
        pushPix(3, 42, 10, 3'b000);
        pushPix(3, 40, 11, 3'b010);
        pushPix(3, 41, 11, 3'b010);
        pushLit(3, 8);
        waitTick(2 * FT + 11 * HT + 41);
        @(negedge clk);
        applyStimulus(20, 5, 3'b010);

        // Frame 4: write (0,0) red, then reset in the middle of line 8.
        waitTick(4 * FT + 2 * HT);
        applyStimulus(0, 0, 3'b100);
        waitTick(4 * FT + 8 * HT + 30);
        checkOutput("sb_drained_before_reset", 32'(sb_q.size()), 32'd0);
        checkOutput("lit_drained_before_reset", 32'(lit_q.size()), 32'd0);
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkResetOutputs("mid_frame_reset");
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checkResetOutputs("mid_frame_release");

        // After release the scan starts over and every earlier write is still there.
        pushPix(0, 0, 0, 3'b100);
        pushPix(0, 1, 0, 3'b100);
        pushPix(0, 2, 0, 3'b000);
        pushPix(0, 0, 1, 3'b100);
        pushPix(0, 1, 1, 3'b100);
        pushPix(0, 2, 2, 3'b000);
        pushPix(0, 10, 6, 3'b101);
        pushPix(0, 40, 10, 3'b010);
        pushLit(0, 12);
        waitTick(FT + 5);
        checkOutput("sb_drained_at_end", 32'(sb_q.size()), 32'd0);
        checkOutput("lit_drained_at_end", 32'(lit_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
